// File: rtl/cpu_output_buffer.sv
// ---------------------------------------------------------------------------
// cpu_output_buffer
//
// Purpose:
//   This module sits on the output side of the CPU core. Each word that the
//   CPU presents on `out` while `outFlag` is high is captured into a small
//   first-word-fall-through FIFO. The words are then drained to an external
//   consumer over a valid/ready handshake. This lets the CPU's single-cycle
//   output strobe work with consumers that may stall.
//
// Parameters:
//   WIDTH    - data word width (default 16)
//   DEPTH    - FIFO entries, power of two, minimum 2 (default 8)
//   PTRWIDTH - log2(DEPTH) (default 3)
//
// Ports:
//   clock         in   single clock, rising edge
//   reset         in   asynchronous, active-low reset
//   outFlag       in   CPU output strobe, one word offered per high cycle
//   out           in   CPU output word
//   dataOut       out  head-of-FIFO word, 0 when empty
//   dataValid     out  FIFO not empty
//   dataReady     in   consumer accepts dataOut when dataValid is high
//   full          out  count == DEPTH
//   empty         out  count == 0
//   count         out  number of stored words, 0..DEPTH
//   overflow      out  sticky drop indicator
//   overflowClear in   synchronous clear of overflow (a same-cycle drop wins)
//   dropCount     out  (only with OUTBUF_DROPCOUNT_EN) saturating count of
//                      dropped words
//
// Optional feature macro: OUTBUF_DROPCOUNT_EN
// ---------------------------------------------------------------------------
module cpu_output_buffer #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int PTRWIDTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                outFlag,
  input  logic [WIDTH-1:0]    out,
  output logic [WIDTH-1:0]    dataOut,
  output logic                dataValid,
  input  logic                dataReady,
  output logic                full,
  output logic                empty,
  output logic [PTRWIDTH:0]   count,
  output logic                overflow,
  input  logic                overflowClear
`ifdef OUTBUF_DROPCOUNT_EN
  ,
  output logic [WIDTH-1:0]    dropCount
`endif
);

  localparam logic [PTRWIDTH:0]   CNT_ZERO = {(PTRWIDTH+1){1'b0}};
  localparam logic [PTRWIDTH:0]   CNT_ONE  = {{PTRWIDTH{1'b0}}, 1'b1};
  localparam logic [PTRWIDTH:0]   CNT_FULL = (PTRWIDTH+1)'(DEPTH);
  localparam logic [PTRWIDTH-1:0] PTR_ZERO = {PTRWIDTH{1'b0}};
  localparam logic [PTRWIDTH-1:0] PTR_ONE  = {{(PTRWIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [PTRWIDTH-1:0] wr_ptr_r;
  logic [PTRWIDTH-1:0] rd_ptr_r;
  logic [PTRWIDTH:0]   count_r;
  logic                overflow_r;

  logic full_s;
  logic empty_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Full and empty are decided by the occupancy counter only. The pointers
  // are equal in both states, so they cannot tell the two apart.
  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);

  // A pop frees a slot in the same cycle. A push to a full FIFO is therefore
  // still accepted when a pop happens alongside it.
  assign pop_s  = ~empty_s & dataReady;
  assign push_s = outFlag & (~full_s | pop_s);
  assign drop_s = outFlag & full_s & ~pop_s;

  // Pointer, occupancy and sticky-overflow state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (overflowClear) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Storage array write port. The array is not reset; the pointers and the
  // counter alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= out;
    end
  end

  // Fall-through head word, forced to zero while nothing is stored.
  always_comb begin
    dataOut = {WIDTH{1'b0}};
    if (empty_s) begin
      dataOut = {WIDTH{1'b0}};
    end else begin
      dataOut = mem_r[rd_ptr_r];
    end
  end

  assign dataValid = ~empty_s;
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign overflow  = overflow_r;

`ifdef OUTBUF_DROPCOUNT_EN
  logic [WIDTH-1:0] drop_cnt_r;

  // Saturating drop counter. A clear together with a drop restarts the
  // count at one, so that drop is still counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= {WIDTH{1'b0}};
    end else if (overflowClear) begin
      drop_cnt_r <= drop_s ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
    end else if (drop_s && !(&drop_cnt_r)) begin
      drop_cnt_r <= drop_cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign dropCount = drop_cnt_r;
`endif

endmodule

// File: tb/tb_cpu_output_buffer.sv
// ---------------------------------------------------------------------------
// tb_cpu_output_buffer
//
// Directed, self-checking bench for cpu_output_buffer. Each task drives one
// scenario and compares the DUT outputs against hand-computed values.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, which is well away from the active edge.
// ---------------------------------------------------------------------------
module tb_cpu_output_buffer;

  localparam int WIDTH    = 16;
  localparam int DEPTH    = 8;
  localparam int PTRWIDTH = 3;

  logic                clock;
  logic                reset;
  logic                outFlag;
  logic [WIDTH-1:0]    out;
  logic [WIDTH-1:0]    dataOut;
  logic                dataValid;
  logic                dataReady;
  logic                full;
  logic                empty;
  logic [PTRWIDTH:0]   count;
  logic                overflow;
  logic                overflowClear;
`ifdef OUTBUF_DROPCOUNT_EN
  logic [WIDTH-1:0]    dropCount;
`endif

  int n_cmp;
  int n_bad;

  cpu_output_buffer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .PTRWIDTH(PTRWIDTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .outFlag      (outFlag),
    .out          (out),
    .dataOut      (dataOut),
    .dataValid    (dataValid),
    .dataReady    (dataReady),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .overflowClear(overflowClear)
`ifdef OUTBUF_DROPCOUNT_EN
    ,
    .dropCount    (dropCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; outFlag = 1'b0; out = 16'h0000;
    dataReady = 1'b0; overflowClear = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (dataValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dataValid); end
    n_cmp++; if (dataOut !== 16'h0000) begin n_bad++; $display("FAIL reset_dataout got %h want 0000", dataOut); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
  endtask

  task automatic test_single();
    outFlag = 1'b1; out = 16'h00A5; dataReady = 1'b0;
    step();
    outFlag = 1'b0;
    n_cmp++; if (dataOut !== 16'h00A5) begin n_bad++; $display("FAIL single_data got %h want 00a5", dataOut); end
    n_cmp++; if (dataValid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", dataValid); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", count); end
    dataReady = 1'b1;
    step();
    dataReady = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL single_empty got %b want 1", empty); end
    n_cmp++; if (dataOut !== 16'h0000) begin n_bad++; $display("FAIL single_gate got %h want 0000", dataOut); end
  endtask

  task automatic test_fill_overflow();
    dataReady = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      outFlag = 1'b1; out = 16'(i);
      step();
      if (i == 8) begin
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full got %b want 1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_noovf got %b want 0", overflow); end
      end
    end
    outFlag = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_ovf got %b want 1", overflow); end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_count got %0d want 8", count); end
`ifdef OUTBUF_DROPCOUNT_EN
    n_cmp++; if (dropCount !== 16'd1) begin n_bad++; $display("FAIL fill_dropcnt got %0d want 1", dropCount); end
`endif
    dataReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++; if (dataOut !== 16'(i)) begin n_bad++; $display("FAIL fill_drain[%0d] got %h want %h", i, dataOut, 16'(i)); end
      step();
    end
    dataReady = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fill_drained got %b want 1", empty); end
    overflowClear = 1'b1;
    step();
    overflowClear = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_clear got %b want 0", overflow); end
  endtask

  task automatic test_full_pushpop();
    dataReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      outFlag = 1'b1; out = 16'h0010 + 16'(i);
      step();
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fpp_full got %b want 1", full); end
    outFlag = 1'b1; out = 16'h0018; dataReady = 1'b1;
    n_cmp++; if (dataOut !== 16'h0010) begin n_bad++; $display("FAIL fpp_head got %h want 0010", dataOut); end
    step();
    outFlag = 1'b0;
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fpp_count got %0d want 8", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (dataOut !== 16'h0011 + 16'(i)) begin n_bad++; $display("FAIL fpp_drain[%0d] got %h want %h", i, dataOut, 16'h0011 + 16'(i)); end
      step();
    end
    dataReady = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fpp_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    dataReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      outFlag = 1'b1; out = 16'(i);
      step();
      // Word i is pushed while word i-1 is popped.
      n_cmp++; if (dataOut !== 16'(i)) begin n_bad++; $display("FAIL stream_data[%0d] got %h want %h", i, dataOut, 16'(i)); end
      n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL stream_count[%0d] got %0d want 1", i, count); end
    end
    outFlag = 1'b0;
    step();
    dataReady = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL stream_empty got %b want 1", empty); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL stream_ovf got %b want 0", overflow); end
  endtask

  task automatic test_async_reset();
    dataReady = 1'b0;
    for (int i = 0; i < 9; i++) begin
      outFlag = 1'b1; out = 16'h0100 + 16'(i);
      step();
    end
    outFlag = 1'b0;
    dataReady = 1'b1;
    step(); step(); step();
    dataReady = 1'b0;
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL arst_precount got %0d want 5", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL arst_preovf got %b want 1", overflow); end
    // Assert reset between edges and check before the next edge arrives.
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL arst_count got %0d want 0", count); end
    n_cmp++; if (dataValid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got %b want 0", dataValid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL arst_ovf got %b want 0", overflow); end
    n_cmp++; if (dataOut !== 16'h0000) begin n_bad++; $display("FAIL arst_data got %h want 0000", dataOut); end
    step();
    reset = 1'b1;
    step();
    // Refill, then drop while clearing: the set wins.
    for (int i = 0; i < 8; i++) begin
      outFlag = 1'b1; out = 16'h0200 + 16'(i);
      step();
    end
    outFlag = 1'b1; out = 16'h0FFF; overflowClear = 1'b1;
    step();
    outFlag = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL clr_drop_ovf got %b want 1", overflow); end
`ifdef OUTBUF_DROPCOUNT_EN
    n_cmp++; if (dropCount !== 16'd1) begin n_bad++; $display("FAIL clr_drop_cnt got %0d want 1", dropCount); end
`endif
    step();
    overflowClear = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_only_ovf got %b want 0", overflow); end
    n_cmp++; if (dataOut !== 16'h0200) begin n_bad++; $display("FAIL clr_head got %h want 0200", dataOut); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_pushpop();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
